// File: rtl/cvxif_result_queue_if.sv
// rtl/cvxif_result_queue_if.sv - result-in, kill and writeback-out signal bundle for the result queue
interface cvxif_result_queue_if #(
  parameter int unsigned ID_WIDTH   = 3,
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  res_valid_i;
  logic                  res_ready_o;
  logic [ID_WIDTH-1:0]   res_id_i;
  logic [DATA_WIDTH-1:0] res_data_i;
  logic [4:0]            res_rd_i;
  logic                  res_we_i;
  logic                  res_exc_i;
  logic [5:0]            res_exccode_i;
  logic                  kill_valid_i;
  logic [ID_WIDTH-1:0]   kill_id_i;
  logic                  wb_valid_o;
  logic                  wb_ready_i;
  logic [ID_WIDTH-1:0]   wb_id_o;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic [4:0]            wb_rd_o;
  logic                  wb_we_o;
  logic                  wb_exc_o;
  logic [5:0]            wb_exccode_o;

  // Environment view: coprocessor result side plus core kill/writeback side
  modport master (
    output res_valid_i, res_id_i, res_data_i, res_rd_i, res_we_i, res_exc_i, res_exccode_i,
    output kill_valid_i, kill_id_i, wb_ready_i,
    input  res_ready_o, wb_valid_o, wb_id_o, wb_data_o, wb_rd_o, wb_we_o, wb_exc_o, wb_exccode_o
  );

  // Queue view
  modport slave (
    input  res_valid_i, res_id_i, res_data_i, res_rd_i, res_we_i, res_exc_i, res_exccode_i,
    input  kill_valid_i, kill_id_i, wb_ready_i,
    output res_ready_o, wb_valid_o, wb_id_o, wb_data_o, wb_rd_o, wb_we_o, wb_exc_o, wb_exccode_o
  );
endinterface

// File: rtl/cvxif_result_queue.sv
// rtl/cvxif_result_queue.sv - in-order CV-X-IF result buffer with kill and flush
module cvxif_result_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ID_WIDTH   = 3,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  cvxif_result_queue_if.slave    bus,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  // Payload storage is never reset: the live bits and pointers say what is valid.
  logic [ID_WIDTH-1:0]   id_q      [DEPTH];
  logic [DATA_WIDTH-1:0] data_q    [DEPTH];
  logic [4:0]            rd_q      [DEPTH];
  logic                  we_q      [DEPTH];
  logic                  exc_q     [DEPTH];
  logic [5:0]            exccode_q [DEPTH];

  logic [DEPTH-1:0] live_q, live_d;
  logic [AW:0]      rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW-1:0]    head, tail;
  logic             full, empty, push, pop;

  assign head  = rptr_q[AW-1:0];
  assign tail  = wptr_q[AW-1:0];
  assign full  = (rptr_q[AW-1:0] == wptr_q[AW-1:0]) && (rptr_q[AW] != wptr_q[AW]);
  assign empty = (rptr_q == wptr_q);

  // Ready depends on registers only, so the core's ready never reaches the coprocessor.
  assign bus.res_ready_o = ~full;
  assign push            = bus.res_valid_i & ~full;

  // A dead head is never shown; it is dropped on its own one entry per cycle.
  assign bus.wb_valid_o = ~empty & live_q[head];
  assign pop            = ~empty & (~live_q[head] | bus.wb_ready_i);

  assign bus.wb_id_o      = id_q[head];
  assign bus.wb_data_o    = data_q[head];
  assign bus.wb_rd_o      = rd_q[head];
  assign bus.wb_exc_o     = exc_q[head];
  assign bus.wb_exccode_o = exccode_q[head];
  assign bus.wb_we_o      = we_q[head] & ~exc_q[head] & bus.wb_valid_o;

  assign count_o = wptr_q - rptr_q;

  // Next pointers and live bits: kill matches, incoming write, then flush overriding all
  always_comb begin
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
    wptr_d = wptr_q + {{AW{1'b0}}, push};
    live_d = live_q;
    if (bus.kill_valid_i) begin
      // Unoccupied slots may be cleared too; their live bit is rewritten on the next push.
      for (int i = 0; i < DEPTH; i++) begin
        if (id_q[i] == bus.kill_id_i) live_d[i] = 1'b0;
      end
    end
    if (push) begin
      live_d[tail] = ~(bus.kill_valid_i && (bus.kill_id_i == bus.res_id_i));
    end
    if (flush_i) begin
      rptr_d = '0;
      wptr_d = '0;
      live_d = '0;
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      live_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      live_q <= live_d;
    end
  end

  // Payload write at the tail; a push coinciding with flush is dropped
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      id_q[tail]      <= bus.res_id_i;
      data_q[tail]    <= bus.res_data_i;
      rd_q[tail]      <= bus.res_rd_i;
      we_q[tail]      <= bus.res_we_i;
      exc_q[tail]     <= bus.res_exc_i;
      exccode_q[tail] <= bus.res_exccode_i;
    end
  end
endmodule

// File: tb/tb_cvxif_result_queue.sv
// tb/tb_cvxif_result_queue.sv - self-checking bench for cvxif_result_queue
module tb_cvxif_result_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [2:0] count;
  bit check_en = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  id;
    logic [63:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [5:0]  exccode;
    bit          live;
  } ent_t;
  ent_t mq[$];

  cvxif_result_queue_if #(.ID_WIDTH(3), .DATA_WIDTH(64)) bus ();

  cvxif_result_queue #(.DEPTH(DEPTH), .ID_WIDTH(3), .DATA_WIDTH(64)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus.slave),
    .count_o (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference queue: FIFO of entries; dead entries leave one per cycle, live ones on ready
  always @(posedge clk) begin
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      bit was_full;
      bit do_pop;
      ent_t e;
      was_full = (mq.size() == DEPTH);
      do_pop = (mq.size() > 0) && (!mq[0].live || bus.wb_ready_i);
      if (bus.kill_valid_i)
        foreach (mq[k]) if (mq[k].id == bus.kill_id_i) mq[k].live = 0;
      if (do_pop) void'(mq.pop_front());
      if (bus.res_valid_i && !was_full) begin
        e.id = bus.res_id_i; e.data = bus.res_data_i; e.rd = bus.res_rd_i;
        e.we = bus.res_we_i; e.exc = bus.res_exc_i; e.exccode = bus.res_exccode_i;
        e.live = !(bus.kill_valid_i && bus.kill_id_i == bus.res_id_i);
        mq.push_back(e);
      end
    end
  end

  // Every-cycle comparison against the reference queue
  always @(negedge clk) begin
    if (check_en) begin
      int n;
      bit ev;
      n = mq.size();
      ev = (n > 0) && mq[0].live;
      chk("count", count, n);
      chk("res_ready", bus.res_ready_o, n != DEPTH);
      chk("wb_valid", bus.wb_valid_o, ev);
      if (ev) begin
        chk("wb_id", bus.wb_id_o, mq[0].id);
        chk("wb_data", bus.wb_data_o, mq[0].data);
        chk("wb_rd", bus.wb_rd_o, mq[0].rd);
        chk("wb_we", bus.wb_we_o, mq[0].we & ~mq[0].exc);
        chk("wb_exc", bus.wb_exc_o, mq[0].exc);
        chk("wb_exccode", bus.wb_exccode_o, mq[0].exccode);
      end else begin
        chk("wb_we_idle", bus.wb_we_o, 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] id, input logic [63:0] data, input logic [4:0] rd,
                      input logic we, input logic exc, input logic [5:0] ec);
    bus.res_valid_i = 1'b1; bus.res_id_i = id; bus.res_data_i = data; bus.res_rd_i = rd;
    bus.res_we_i = we; bus.res_exc_i = exc; bus.res_exccode_i = ec;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    bus.res_valid_i = 0; bus.res_id_i = 0; bus.res_data_i = 0; bus.res_rd_i = 0;
    bus.res_we_i = 0; bus.res_exc_i = 0; bus.res_exccode_i = 0;
    bus.kill_valid_i = 0; bus.kill_id_i = 0; bus.wb_ready_i = 0;
    cyc(); cyc();
    rst_n = 1'b1; check_en = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_ready", bus.res_ready_o, 1);
    chk("rst_valid", bus.wb_valid_o, 0);

    // single push, one-cycle latency, then pop
    push(3'd2, 64'h15, 5'd5, 1, 0, 0);
    cyc();
    bus.res_valid_i = 0; bus.wb_ready_i = 1;
    chk("t1_valid", bus.wb_valid_o, 1);
    chk("t1_data", bus.wb_data_o, 64'h15);
    chk("t1_rd", bus.wb_rd_o, 5);
    chk("t1_we", bus.wb_we_o, 1);
    chk("t1_count", count, 1);
    cyc();
    chk("t1_count_after", count, 0);

    // fill, overflow attempt, in-order drain
    bus.wb_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      push(i[2:0], 64'h100 + 64'(i), 5'(i), 1, 0, 0);
      cyc();
    end
    chk("fill_ready", bus.res_ready_o, 0);
    chk("fill_count", count, 4);
    push(3'd7, 64'hdead, 5'd9, 1, 0, 0);
    cyc();
    chk("ovf_count", count, 4);
    bus.res_valid_i = 0; bus.wb_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_id", bus.wb_id_o, i);
      cyc();
    end
    chk("drain_count", count, 0);

    // kill in the middle leaves a bubble
    bus.wb_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      push(i[2:0], 64'h200 + 64'(i), 5'd1, 1, 0, 0);
      cyc();
    end
    bus.res_valid_i = 0; bus.kill_valid_i = 1; bus.kill_id_i = 3'd1;
    cyc();
    bus.kill_valid_i = 0; bus.wb_ready_i = 1;
    chk("kill_head_valid", bus.wb_valid_o, 1);
    chk("kill_head_id", bus.wb_id_o, 0);
    cyc();
    chk("kill_bubble", bus.wb_valid_o, 0);
    cyc();
    chk("kill_next_valid", bus.wb_valid_o, 1);
    chk("kill_next_id", bus.wb_id_o, 2);
    cyc();
    chk("kill_count", count, 0);

    // kill of the incoming result
    push(3'd3, 64'h33, 5'd3, 1, 0, 0);
    bus.kill_valid_i = 1; bus.kill_id_i = 3'd3;
    cyc();
    bus.res_valid_i = 0; bus.kill_valid_i = 0;
    chk("kin_count1", count, 1);
    chk("kin_valid", bus.wb_valid_o, 0);
    cyc();
    chk("kin_count0", count, 0);
    chk("kin_valid2", bus.wb_valid_o, 0);

    // exception gates writeback enable
    bus.wb_ready_i = 0;
    push(3'd4, 64'h44, 5'd4, 1, 1, 6'd2);
    cyc();
    bus.res_valid_i = 0;
    chk("exc_valid", bus.wb_valid_o, 1);
    chk("exc_we", bus.wb_we_o, 0);
    chk("exc_exc", bus.wb_exc_o, 1);
    chk("exc_code", bus.wb_exccode_o, 2);
    bus.wb_ready_i = 1;
    cyc();

    // random traffic across pointer wrap, checked against the reference queue
    for (int i = 0; i < 20; i++) begin
      bus.res_valid_i = 1'($urandom_range(0, 1));
      bus.res_id_i = 3'($urandom_range(0, 7));
      bus.res_data_i = {$urandom(), $urandom()};
      bus.res_rd_i = 5'($urandom_range(0, 31));
      bus.res_we_i = 1'($urandom_range(0, 1));
      bus.res_exc_i = ($urandom_range(0, 3) == 0);
      bus.res_exccode_i = 6'($urandom_range(0, 63));
      bus.kill_valid_i = ($urandom_range(0, 3) == 0);
      bus.kill_id_i = 3'($urandom_range(0, 7));
      bus.wb_ready_i = 1'($urandom_range(0, 1));
      cyc();
    end
    bus.res_valid_i = 0; bus.kill_valid_i = 0; bus.wb_ready_i = 1;
    repeat (5) cyc();
    chk("rand_drained", count, 0);

    // flush with three entries held; concurrent push is dropped
    bus.wb_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      push(3'(i + 5), 64'h300 + 64'(i), 5'd2, 1, 0, 0);
      cyc();
    end
    chk("pre_flush_count", count, 3);
    flush = 1'b1;
    cyc();
    flush = 1'b0; bus.res_valid_i = 0;
    chk("flush_count", count, 0);
    chk("flush_valid", bus.wb_valid_o, 0);

    // reset in the middle of traffic
    push(3'd1, 64'h55, 5'd6, 1, 0, 0);
    cyc(); cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; bus.res_valid_i = 0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", bus.wb_valid_o, 0);
    chk("mid_rst_ready", bus.res_ready_o, 1);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cvxif_result_queue.md
Name: cvxif_result_queue

Overview:
- Buffers CV-X-IF result packets from the coprocessor's result interface before they reach the core writeback port.
- Sits directly downstream of the example coprocessor, between its result interface and the core.
- Breaks the combinational path from the core's result ready back into the coprocessor.
- Absorbs results in order and discards entries whose instruction the core later kills.

Parameters:
DEPTH, 4, number of result entries; power of two, at least 2
ID_WIDTH, 3, width of the instruction ID (matches the CV-X-IF ID width)
DATA_WIDTH, 64, result data width (matches the register-file width)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
flush_i  in  1  drop all entries
res_valid_i  in  1  coprocessor result valid
res_ready_o  out  1  queue can accept a result
res_id_i  in  ID_WIDTH  result instruction ID
res_data_i  in  DATA_WIDTH  result data
res_rd_i  in  5  destination register
res_we_i  in  1  writeback enable
res_exc_i  in  1  exception flag
res_exccode_i  in  6  exception code
kill_valid_i  in  1  commit-kill strobe
kill_id_i  in  ID_WIDTH  ID being killed
wb_valid_o  out  1  result presented to the core
wb_ready_i  in  1  core accepts the result
wb_id_o  out  ID_WIDTH  head ID
wb_data_o  out  DATA_WIDTH  head data
wb_rd_o  out  5  head rd
wb_we_o  out  1  head writeback enable, gated
wb_exc_o  out  1  head exception flag
wb_exccode_o  out  6  head exception code
count_o  out  $clog2(DEPTH)+1  occupied entries, including killed entries not yet drained

Behaviour:
- Reset and clock: one clock, clk_i. Reset is synchronous and active-low: rst_ni is sampled only at the rising edge of clk_i.
- State:
  - circular buffer of DEPTH entries, each holding id, data, rd, we, exc, exccode and a live bit;
  - read pointer and write pointer, each $clog2(DEPTH)+1 bits, with the extra MSB used for the wrap flag.
- Full/empty:
  - full when the pointer LSBs are equal and the MSBs differ;
  - empty when the pointers are equal;
  - count_o = wptr - rptr, modulo 2^($clog2(DEPTH)+1).
- Reset (rst_ni=0 at a clock edge): pointers cleared and all live bits cleared. Resulting outputs:
  - res_ready_o=1;
  - wb_valid_o=0, count_o=0;
  - all wb_* data outputs equal to entry 0 contents, which are don't-care and not reset.
- Input handshake:
  - res_ready_o = ~full, derived from registers only, with no path from wb_ready_i;
  - a write occurs when res_valid_i & res_ready_o;
  - the entry is stored with live=1, except live=0 when kill_valid_i & kill_id_i==res_id_i in the same cycle;
  - a killed incoming result still occupies a slot and drains as a bubble.
- Output:
  - wb_valid_o = ~empty & live[head], combinational from registers only;
  - wb_we_o = we[head] & ~exc[head] & wb_valid_o;
  - the remaining wb_* fields come straight from the head entry.
- Latency: a result written in cycle N is visible at wb_* in cycle N+1 when the queue was empty. No fall-through path exists.
- Pop:
  - occurs on wb_valid_o & wb_ready_i, or automatically when ~empty & ~live[head] (killed head);
  - an auto-pop takes one cycle per dead entry;
  - wb_valid_o stays 0 during an auto-pop.
- Kill:
  - on kill_valid_i, every occupied entry with a matching id has its live bit cleared at the next edge;
  - kill_valid_i does not affect wb_valid_o in the current cycle;
  - if the head handshakes in the same cycle as a matching kill, the transfer completes and the kill has no further effect on that entry.
- Simultaneous push and pop:
  - allowed at any occupancy;
  - when full, a pop frees the slot only at the next edge, because res_ready_o is registered-derived; no write occurs that cycle;
  - when empty, a push is not visible until the next cycle.
- Pointer wrap: pointers wrap modulo 2·DEPTH and ordering is preserved across the wrap.
- flush_i: next edge behaves as reset for the pointers and live bits. If flush_i and a push occur in the same cycle, flush wins and the push is dropped.
- IDs:
  - duplicate IDs in flight are legal;
  - a kill clears all matching entries.

Test Plan:
- Reset then single push: id=2, data=0x15, rd=5, we=1 in cycle 0 -> cycle 1 shows wb_valid_o=1, wb_data_o=0x15, wb_rd_o=5, wb_we_o=1, count_o=1; wb_ready_i=1 -> count_o=0 in cycle 2.
- Fill: push ids 0..3 with wb_ready_i=0 -> res_ready_o=0 and count_o=4 after the 4th push; a 5th push is ignored; drain yields ids 0,1,2,3 in order.
- Kill in the middle: queue holds ids 0,1,2 and kill_id_i=1 is pulsed -> outputs id 0, one bubble cycle with wb_valid_o=0, then id 2; count_o reaches 0.
- Kill of the incoming result: res id=3 pushed with kill_valid_i=1, kill_id_i=3 in the same cycle into an empty queue -> wb_valid_o never asserts; count_o goes 1 then 0.
- Exception gating: push we=1, exc=1, exccode=2 -> wb_valid_o=1, wb_we_o=0, wb_exc_o=1, wb_exccode_o=2.
- Wrap and flush:
  - 20 random push/pop cycles at DEPTH=4 -> outputs match a reference FIFO model;
  - then flush_i=1 with 3 entries held -> count_o=0 and wb_valid_o=0 next cycle;
  - rst_ni=0 mid-traffic -> same cleared state at the next edge.
